// File: rtl/s2p_pkg.sv
// Shared definitions for the serial-to-parallel frame controller:
// FSM state encodings and the counter-width helper.
package s2p_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_PAR  = 2'd2;

   // Bits needed to hold 0..v-1, never less than one.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/s2p_shreg.sv
// WIDTH-bit right-shift register, new bit enters at the MSB so the
// first bit received ends up in bit 0.
module s2p_shreg #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_sdi,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (i_clr)     r_q <= '0;
      else if (i_en) r_q <= {i_sdi, r_q[WIDTH-1:1]};
   end

   assign o_q = r_q;

endmodule

// File: rtl/s2p_frame_ctrl.sv
// Frame controller and deserializer: sync-framed serial bits in, parity
// checked parallel words out over valid/ready with error/overflow pulses.
module s2p_frame_ctrl
   import s2p_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter bit          PAR_EN  = 1'b1,
   parameter bit          PAR_ODD = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_en,
   input  logic             sync,
   input  logic             sdi,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             busy,
   output logic             par_err,
   output logic             frm_err,
   output logic             ovf
);

   localparam int unsigned CW = clog2(WIDTH);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [WIDTH-1:0] w_shreg;
   logic [WIDTH-1:0] w_word;
   logic             w_shift;
   logic             w_done;
   logic             w_perr;
   logic             w_ferr;
   logic             w_par_ok;
   logic             w_load;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_busy;
   logic             r_par_err;
   logic             r_frm_err;
   logic             r_ovf;

   s2p_shreg #(.WIDTH(WIDTH)) u_shreg (
      .clk   (clk),
      .i_clr (rst),
      .i_en  (w_shift),
      .i_sdi (sdi),
      .o_q   (w_shreg)
   );

   // In PAR the data bits are already in place; otherwise the word includes this bit.
   assign w_word   = (r_state == S_PAR) ? w_shreg : {sdi, w_shreg[WIDTH-1:1]};
   assign w_par_ok = ((^w_shreg) ^ sdi) == PAR_ODD;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state, counter and event decode; a sync bit always restarts the frame.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shift     = 1'b0;
      w_done      = 1'b0;
      w_perr      = 1'b0;
      w_ferr      = 1'b0;
      if (bit_en) begin
         if (sync) begin
            w_ferr      = (r_state != S_IDLE);
            w_shift     = 1'b1;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = S_DATA;
         end else begin
            case (r_state)
               S_DATA: begin
                  w_shift = 1'b1;
                  if (r_cnt == CW'(WIDTH - 1)) begin
                     w_cnt_nxt = '0;
                     if (PAR_EN) begin
                        w_state_nxt = S_PAR;
                     end else begin
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                     end
                  end else begin
                     w_cnt_nxt = r_cnt + CW'(1);
                  end
               end
               S_PAR: begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_IDLE;
                  w_done      = w_par_ok;
                  w_perr      = !w_par_ok;
               end
               default: w_state_nxt = S_IDLE;
            endcase
         end
      end
   end

   assign w_load = w_done && (!r_valid || m_ready);

   // Output word register, status and one-cycle event pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_par_err <= 1'b0;
         r_frm_err <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_busy    <= (w_state_nxt != S_IDLE);
         r_par_err <= w_perr;
         r_frm_err <= w_ferr;
         r_ovf     <= w_done && !w_load;
         if (w_load) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
         end else if (r_valid && m_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign m_data  = r_data;
   assign m_valid = r_valid;
   assign busy    = r_busy;
   assign par_err = r_par_err;
   assign frm_err = r_frm_err;
   assign ovf     = r_ovf;

endmodule

// File: doc/s2p_frame_ctrl.md
Name: s2p_frame_ctrl

Overview:
Frame controller and deserializer for a strobed serial bit stream. It detects frame start and counts WIDTH data bits into an internal right-shift register. It optionally checks a trailing parity bit, then hands the parallel word downstream over a valid/ready interface. It sits between a serial line front-end and any parallel consumer, and replaces free-running shift/load control with explicit sequencing, framing errors and backpressure.

Parameters:
WIDTH, 4, data bits per frame (2..32)
PAR_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity phase
PAR_ODD, 0, parity sense when PAR_EN=1 (0 even, 1 odd)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
bit_en  in  1  bit strobe; sdi/sync sampled only when high
sync  in  1  frame-start marker, qualified by bit_en
sdi  in  1  serial data, LSB first
m_data  out  WIDTH  parallel word, registered
m_valid  out  1  m_data holds an undelivered word
m_ready  in  1  consumer accepts m_data when m_valid&&m_ready
busy  out  1  frame in progress (state != IDLE)
par_err  out  1  one-cycle pulse: parity mismatch, word dropped
frm_err  out  1  one-cycle pulse: sync seen mid-frame, partial frame aborted
ovf  out  1  one-cycle pulse: word completed while output full, word dropped

Behaviour:
- Reset: state=IDLE, bit counter=0, shift reg=0, m_data=0, m_valid=0, busy=0, all pulses 0. Reset mid-frame discards everything, including a pending m_valid word.
- Shift register: on each accepted bit, shreg <= {sdi, shreg[WIDTH-1:1]}. The first bit received ends up in m_data[0].
- States: IDLE, DATA, PAR.
- IDLE: bit_en&&sync -> sample sdi as bit 0, cnt=1, go to DATA. For WIDTH bits, WIDTH=1 is not allowed. bit_en without sync is ignored.
- DATA: each bit_en shifts sdi and increments cnt.
  - On the bit where cnt==WIDTH-1: go to PAR if PAR_EN=1, otherwise complete the word and return to IDLE.
- PAR: next bit_en samples the parity bit.
  - Check: ^{shreg, sdi} must equal PAR_ODD.
  - Match: complete the word. Mismatch: par_err pulse, word dropped. Either way, return to IDLE.
- Sync mid-frame (bit_en&&sync in DATA or PAR): frm_err pulse, partial frame discarded. The same bit is bit 0 of a new frame, cnt=1, state DATA.
- Word completion, evaluated in the completing cycle:
  - If m_valid==0 or m_ready==1: next cycle m_data=word and m_valid=1.
  - Otherwise: ovf pulse, m_data/m_valid unchanged, word dropped.
- Latency: m_valid rises on the clock edge after the final data or parity bit is sampled.
- Handshake: once m_valid=1, m_data is stable until m_valid&&m_ready. On that handshake, m_valid clears unless a new word completes in the same cycle, in which case m_data is replaced and m_valid stays 1.
- m_ready is ignored while m_valid=0.
- busy=1 in DATA and PAR.
- Pulse outputs are registered, high for exactly one cycle, and mutually exclusive per event. If frm_err and a completing word would coincide, sync wins (frm_err).
- bit_en low holds all state; there is no timeout.

Decomposition:
- Shared package s2p_pkg: state enum {IDLE, DATA, PAR} and the counter-width function clog2(WIDTH).
- One sub-module, s2p_shreg: WIDTH-bit right-shift register with shift enable and synchronous clear.
- Control FSM, parity check and output register live in s2p_frame_ctrl.

Test Plan:
- WIDTH=4, PAR_EN=1, even: sync with bits 1,0,1,1, parity 1 -> m_data=4'b1101, m_valid=1 one cycle after the parity bit, par_err=0.
- Same frame with parity 0 -> par_err pulses once, m_valid stays 0.
- Sync again after 2 data bits, then 4 bits 0,0,1,0 plus parity 1 -> frm_err pulse at the restart, m_data=4'b0100.
- Hold m_ready=0 with m_valid=1 (4'b1101) and send a second frame -> ovf pulse, m_data stays 4'b1101. Raise m_ready -> m_valid clears.
- Word completes in the same cycle as m_ready=1 on a pending word -> m_valid stays 1, m_data updates to the new word, no ovf.
- Assert rst mid-frame after 2 bits, then a full clean frame -> no m_valid from the partial frame, correct word from the clean one. bit_en gaps of 0-3 cycles between bits give an identical result.
